// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
// FSM state encoding and baud divider computation.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Head word is presented combinationally on rdata_o.
module uart_tx_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input,
// FIFO, and LSB-first serialiser with a registered line output.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 48_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       uart_txo,
  output logic       busy
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned AW  = $clog2(DEPTH);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [7:0]    fifo_rdata;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push, pop;
  logic          bit_end;

  assign data_ready = rst_n && !fifo_full;
  assign push       = data_valid && data_ready;
  assign bit_end    = (baud_q == CW'(CPB - 1));
  assign uart_txo   = tx_q;
  assign busy       = busy_q;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (data_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && bit_q == 3'(DATA_BITS - 1))
          state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on any state entry, including STOP->START.
    if (state_d != state_q || bit_end || state_q == IDLE)
      baud_d = '0;
    else
      baud_d = baud_q + 1'b1;

    bit_d = bit_q;
    if (state_q == START)
      bit_d = '0;
    else if (state_q == DATA && bit_end)
      bit_d = bit_q + 1'b1;

    shreg_d = shreg_q;
    if (pop)
      shreg_d = fifo_rdata;
    else if (state_q == DATA && bit_end)
      shreg_d = {1'b0, shreg_q[7:1]};
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      state_q == START: tx_d = 1'b0;
      state_q == DATA:  tx_d = shreg_q[0];
      default:          tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (fifo_count != '0);
  end

endmodule
